// File: rtl/mod_inverse_seq_pkg.sv
// Shared types and constants for the sequential modular-inverse engine.
package mod_inverse_pkg;

  localparam int DEF_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DIV,
    UPDATE,
    FINAL
  } state_t;

  // Bezout coefficient / Horner accumulator word at the default width
  typedef logic signed [DEF_WIDTH+1:0] tval_t;

  // Worst-case start-to-done cycles: 2 + k*(width+1) with k <= 1.45*width + 2
  function automatic int latency_bound(input int width);
    int kmax;
    kmax = (145 * width + 99) / 100 + 2;
    return 2 + kmax * (width + 1);
  endfunction

endpackage

// File: rtl/mod_inverse_seq_if.sv
// Request/response bundle between a client and the modular-inverse engine.
interface mod_inverse_seq_if #(
  parameter int WIDTH = 64
);

  logic             start;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] modulo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] inverse;
  logic             valid;

  modport master (
    output start, num, modulo,
    input  busy, done, inverse, valid
  );

  modport slave (
    input  start, num, modulo,
    output busy, done, inverse, valid
  );

endinterface

// File: rtl/mod_inverse_seq_divstep.sv
// Restoring divider (one quotient bit per cycle, MSB first) fused with a
// Horner accumulator so that acc ends up as quotient*t1 without ever
// storing the quotient. Runs exactly WIDTH cycles while go is held high;
// rdy marks the cycle whose edge writes the final rem/acc.
module mod_inv_divstep #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [WIDTH-1:0]        dividend,
  input  logic [WIDTH-1:0]        divisor,
  input  logic signed [WIDTH+1:0] t1,
  output logic [WIDTH-1:0]        rem,
  output logic signed [WIDTH+1:0] acc,
  output logic                    rdy
);

  logic [CNT_W-1:0]        cnt;
  logic [WIDTH-1:0]        rem_q;
  logic [WIDTH-1:0]        quo_q;
  logic signed [WIDTH+1:0] acc_q;

  logic [WIDTH-1:0]        cur_quo;
  logic [WIDTH:0]          trial;
  logic                    qbit;
  logic [WIDTH-1:0]        rem_next;
  logic [WIDTH-1:0]        quo_next;
  logic signed [WIDTH+1:0] acc_next;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    cur_quo  = (cnt == '0) ? dividend : quo_q;
    trial    = {rem_q, cur_quo[WIDTH-1]};
    qbit     = (trial >= {1'b0, divisor});
    rem_next = qbit ? WIDTH'(trial - {1'b0, divisor}) : WIDTH'(trial);
    quo_next = cur_quo << 1;
    acc_next = (acc_q <<< 1) + (qbit ? t1 : '0);
    rdy      = go && (cnt == CNT_W'(WIDTH - 1));
  end

  // Step registers advance while go is high and clear between divisions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      acc_q <= '0;
    end else if (!go) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      acc_q <= '0;
    end else begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      acc_q <= acc_next;
      cnt   <= rdy ? '0 : cnt + CNT_W'(1);
    end
  end

  assign rem = rem_q;
  assign acc = acc_q;

endmodule

// File: rtl/mod_inverse_seq.sv
// Sequential modular inverse via the iterative extended Euclidean algorithm.
// Only the t-coefficient is tracked (r_i == t_i * a mod m), so the final
// coefficient next to gcd==1 is the inverse after folding negatives into [0,m).
module mod_inverse_seq
  import mod_inverse_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               rst,
  mod_inverse_seq_if.slave  bus
);

  typedef logic signed [WIDTH+1:0] tw_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  tw_t              t0;
  tw_t              t1;

  logic             busy_q;
  logic             done_q;
  logic             valid_q;
  logic [WIDTH-1:0] inv_q;

  logic             div_go;
  logic             div_rdy;
  logic [WIDTH-1:0] div_rem;
  tw_t              div_acc;

  tw_t              m_ext;
  tw_t              t0_mag;
  tw_t              t1_mag;
  tw_t              acc_mag;

  assign div_go = (state == DIV);

  mod_inv_divstep #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_divstep (
    .clk      (clk),
    .rst      (rst),
    .go       (div_go),
    .dividend (r0),
    .divisor  (r1),
    .t1       (t1),
    .rem      (div_rem),
    .acc      (div_acc),
    .rdy      (div_rdy)
  );

  // Control FSM plus remainder/coefficient registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      r0      <= '0;
      r1      <= '0;
      t0      <= '0;
      t1      <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      inv_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.num;
            m_q     <= bus.modulo;
            inv_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          r0 <= m_q;
          r1 <= a_q;
          t0 <= '0;
          t1 <= tw_t'(1);
          // a zero divisor must never reach DIV; FINAL sorts out m==0/m==1/a==0
          if (m_q == '0 || a_q == '0) state <= FINAL;
          else                        state <= DIV;
        end
        DIV: begin
          if (div_rdy) state <= UPDATE;
        end
        UPDATE: begin
          r0 <= r1;
          r1 <= div_rem;
          t0 <= t1;
          t1 <= t0 - div_acc;
          state <= (div_rem == '0) ? FINAL : DIV;
        end
        FINAL: begin
          if (m_q == WIDTH'(1)) begin
            valid_q <= 1'b1;
            inv_q   <= '0;
          end else if (r0 == WIDTH'(1)) begin
            valid_q <= 1'b1;
            inv_q   <= t0[WIDTH+1] ? t0[WIDTH-1:0] + m_q : t0[WIDTH-1:0];
          end else begin
            valid_q <= 1'b0;
            inv_q   <= '0;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Magnitudes of the signed words for the overflow guard below
  always_comb begin
    m_ext   = $signed({2'b00, m_q});
    t0_mag  = t0[WIDTH+1] ? -t0 : t0;
    t1_mag  = t1[WIDTH+1] ? -t1 : t1;
    acc_mag = div_acc[WIDTH+1] ? -div_acc : div_acc;
  end

  // |t| <= m and |acc| <= 2m keep WIDTH+2 signed bits free of overflow
  assert property (@(posedge clk) disable iff (rst)
    ((state inside {DIV, UPDATE, FINAL}) && (m_q != '0)) |->
      ((t0_mag <= m_ext) && (t1_mag <= m_ext) && (acc_mag <= (m_ext <<< 1))));

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.valid   = valid_q;
  assign bus.inverse = inv_q;

endmodule

// File: tb/tb_mod_inverse_seq.sv
// Directed and randomized checks of mod_inverse_seq against a plain-arithmetic
// extended-Euclid reference.
module tb_mod_inverse_seq;
  import mod_inverse_pkg::*;

  localparam int WIDTH = 64;
  localparam int BOUND = latency_bound(WIDTH);

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  mod_inverse_seq_if #(.WIDTH(WIDTH)) bus ();

  mod_inverse_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inverse of a modulo m from the textbook Bezout recurrence on (m, a mod m)
  function automatic void refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m,
                                   output logic v, output logic [WIDTH-1:0] inv);
    logic signed [2*WIDTH+3:0] r0, r1, t0, t1, q, tmp, ms;
    v   = 1'b0;
    inv = '0;
    if (m == '0) return;
    if (m == WIDTH'(1)) begin
      v = 1'b1;
      return;
    end
    ms = $signed({(WIDTH + 4)'(0), m});
    r0 = ms;
    r1 = $signed({(WIDTH + 4)'(0), a % m});
    t0 = '0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = t0 - q * t1;
      t0  = t1;
      t1  = tmp;
    end
    if (r0 == 1) begin
      v = 1'b1;
      if (t0 < 0) t0 = t0 + ms;
      inv = t0[WIDTH-1:0];
    end
  endfunction

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.num    = a;
    bus.modulo = m;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output logic gotDone, output logic busyOk);
    cycles = 0;
    busyOk = 1'b1;
    while (!bus.done && cycles < BOUND + 4) begin
      if (!bus.busy) busyOk = 1'b0;
      @(negedge clk);
      cycles++;
    end
    gotDone = bus.done;
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m,
                       input string tag, output int cycles);
    logic             expV;
    logic [WIDTH-1:0] expI;
    logic             got;
    logic             bok;
    applyStimulus(a, m);
    waitDone(cycles, got, bok);
    refModel(a, m, expV, expI);
    checkOutput({tag, "_done"},  WIDTH'(got), WIDTH'(1));
    checkOutput({tag, "_busy"},  WIDTH'(bok), WIDTH'(1));
    checkOutput({tag, "_bound"}, WIDTH'(cycles <= BOUND), WIDTH'(1));
    checkOutput({tag, "_valid"}, WIDTH'(bus.valid), WIDTH'(expV));
    checkOutput({tag, "_inv"},   bus.inverse, expI);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, WIDTH'(bus.done), WIDTH'(0));
    checkOutput({tag, "_hold"},  bus.inverse, expI);
  endtask

  // Linear directed sequence followed by randomized operands
  initial begin
    int               cyc;
    logic             got;
    logic             bok;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rm;

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.num    = '0;
    bus.modulo = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",  WIDTH'(bus.busy),  WIDTH'(0));
    checkOutput("rst_done",  WIDTH'(bus.done),  WIDTH'(0));
    checkOutput("rst_valid", WIDTH'(bus.valid), WIDTH'(0));
    checkOutput("rst_inv",   bus.inverse,       WIDTH'(0));
    rst = 1'b0;

    runOp(64'd5, 64'd96, "a5m96", cyc);
    checkOutput("a5m96_const", bus.inverse, 64'd77);
    runOp(64'd100, 64'd7, "a100m7", cyc);
    checkOutput("a100m7_const", bus.inverse, 64'd4);
    runOp(64'd3, 64'd11, "a3m11", cyc);
    checkOutput("a3m11_const", bus.inverse, 64'd4);
    runOp(64'd6, 64'd9, "a6m9", cyc);
    checkOutput("a6m9_const_valid", WIDTH'(bus.valid), WIDTH'(0));
    runOp(64'd10, 64'd0, "m0", cyc);
    checkOutput("m0_latency", WIDTH'(cyc), WIDTH'(2));
    checkOutput("m0_const_valid", WIDTH'(bus.valid), WIDTH'(0));
    runOp(64'd5, 64'd1, "m1", cyc);
    checkOutput("m1_const_valid", WIDTH'(bus.valid), WIDTH'(1));
    runOp(64'd0, 64'd96, "a0", cyc);
    runOp(64'd2, (64'd1 << 61) - 64'd1, "mersenne61", cyc);
    checkOutput("mersenne61_const", bus.inverse, 64'd1152921504606846976);

    // Second start mid-run must be ignored
    applyStimulus(64'd5, 64'd96);
    repeat (20) @(negedge clk);
    bus.start  = 1'b1;
    bus.num    = 64'd3;
    bus.modulo = 64'd11;
    @(negedge clk);
    bus.start  = 1'b0;
    waitDone(cyc, got, bok);
    checkOutput("restart_done",  WIDTH'(got),       WIDTH'(1));
    checkOutput("restart_busy",  WIDTH'(bok),       WIDTH'(1));
    checkOutput("restart_valid", WIDTH'(bus.valid), WIDTH'(1));
    checkOutput("restart_inv",   bus.inverse,       64'd77);
    @(negedge clk);

    // Asynchronous reset in the middle of a division
    applyStimulus(64'd5, 64'd96);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy",  WIDTH'(bus.busy),  WIDTH'(0));
    checkOutput("arst_done",  WIDTH'(bus.done),  WIDTH'(0));
    checkOutput("arst_valid", WIDTH'(bus.valid), WIDTH'(0));
    checkOutput("arst_inv",   bus.inverse,       WIDTH'(0));
    @(negedge clk);
    rst = 1'b0;
    runOp(64'd5, 64'd96, "after_rst", cyc);
    checkOutput("after_rst_const", bus.inverse, 64'd77);

    // Random full-width operands, half with odd moduli to favour invertible cases
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom(), $urandom()};
      rm = {$urandom(), $urandom()};
      if (i % 2 == 0) rm[0] = 1'b1;
      runOp(ra, rm, $sformatf("rnd64_%0d", i), cyc);
    end

    // Random narrow operands exercise short Euclid chains and small moduli
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom_range(0, 4095));
      rm = WIDTH'($urandom_range(0, 300));
      runOp(ra, rm, $sformatf("rnd12_%0d", i), cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
